// File: rtl/operand2_shifter_if.sv
// Operand2 stage bundle: decoded-instruction offer from upstream and the ALU-facing result.
// No storage of its own; it only groups the wires for the stage.
// in_valid/in_ready on the upstream side, out_valid/out_ready on the ALU side.
interface operand2_shifter_if;
    // upstream offer
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cond_in;
    logic [4:0]  operation_in;
    logic [31:0] rn_data;
    logic [31:0] rm_data;
    logic [31:0] rs_data;
    logic        imm_flag;
    logic [11:0] op2_field;
    logic        carry_in;
    // ALU-facing result
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  cond;
    logic [4:0]  operation;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        shifter_carry;

    // driven by the upstream decoder and the ALU
    modport master (
        output in_valid, cond_in, operation_in, rn_data, rm_data, rs_data,
               imm_flag, op2_field, carry_in, out_ready,
        input  in_ready, out_valid, cond, operation, data1, data2, shifter_carry
    );

    // the shifter stage itself
    modport slave (
        input  in_valid, cond_in, operation_in, rn_data, rm_data, rs_data,
               imm_flag, op2_field, carry_in, out_ready,
        output in_ready, out_valid, cond, operation, data1, data2, shifter_carry
    );
endinterface

// File: rtl/operand2_shifter.sv
// ARM Operand2 shifter with a one-entry registered output buffer feeding the ALU.
// Latency: 1 cycle for immediate forms, 2 cycles for register-specified shifts.
// Backpressure: in_ready drops while shifting or while the buffer is full and out_ready is low.
module operand2_shifter (
    input  logic              clk,
    input  logic              reset,
    operand2_shifter_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, SHIFT, FULL} state_t;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    state_t      state;
    logic [31:0] rm_q;
    logic [7:0]  rs_q;
    logic [1:0]  typ_q;
    logic        cin_q;

    logic        accept;
    logic        reg_form;
    logic [32:0] imm_res;   // {carry, data}
    logic [32:0] reg_res;   // {carry, data}
    logic        unused_rs_hi;

    // Only the low byte of Rs is a shift amount.
    assign unused_rs_hi = ^bus.rs_data[31:8];

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] t;
        t = {x, x} >> amt;
        return t[31:0];
    endfunction

    // Shift core for amounts 1..32 (1..31 for ROR); returns {carry, data}.
    // The extra bit beside the data catches the last bit shifted out.
    function automatic logic [32:0] barrel(input logic [31:0] rm, input logic [1:0] typ,
                                           input logic [5:0] amt);
        logic [32:0] t;
        logic [31:0] r;
        logic [32:0] res;
        case (typ)
            SH_LSL: begin
                t   = {1'b0, rm} << amt;
                res = t;
            end
            SH_LSR: begin
                t   = {rm, 1'b0} >> amt;
                res = {t[0], t[32:1]};
            end
            SH_ASR: begin
                t   = $unsigned($signed({rm, 1'b0}) >>> amt);
                res = {t[0], t[32:1]};
            end
            default: begin
                r   = ror32(rm, amt[4:0]);
                res = {r[31], r};
            end
        endcase
        return res;
    endfunction

    // Immediate rotate (I=1) or shift by the 5-bit immediate amount (I=0, bit4=0).
    function automatic logic [32:0] imm_operand(input logic imm, input logic [11:0] f,
                                                input logic [31:0] rm, input logic cin);
        logic [31:0] rot;
        logic [32:0] res;
        if (imm) begin
            rot = ror32({24'd0, f[7:0]}, {f[11:8], 1'b0});
            res = {(f[11:8] == 4'd0) ? cin : rot[31], rot};
        end else if (f[11:7] != 5'd0) begin
            res = barrel(rm, f[6:5], {1'b0, f[11:7]});
        end else begin
            // A zero amount encodes LSL #0, LSR #32, ASR #32 and RRX.
            case (f[6:5])
                SH_LSL:  res = {cin, rm};
                SH_ROR:  res = {rm[0], cin, rm[31:1]};
                default: res = barrel(rm, f[6:5], 6'd32);
            endcase
        end
        return res;
    endfunction

    // Shift by the register amount; large amounts saturate per shift type.
    function automatic logic [32:0] reg_operand(input logic [31:0] rm, input logic [1:0] typ,
                                                input logic [7:0] s, input logic cin);
        logic [32:0] res;
        if (s == 8'd0) begin
            res = {cin, rm};
        end else begin
            case (typ)
                SH_LSL, SH_LSR: res = (s > 8'd32) ? 33'd0 : barrel(rm, typ, s[5:0]);
                SH_ASR:         res = (s >= 8'd32) ? barrel(rm, typ, 6'd32)
                                                   : barrel(rm, typ, s[5:0]);
                default:        res = (s[4:0] == 5'd0) ? {rm[31], rm}
                                                       : barrel(rm, typ, {1'b0, s[4:0]});
            endcase
        end
        return res;
    endfunction

    assign bus.in_ready = (state == EMPTY) || ((state == FULL) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign reg_form     = !bus.imm_flag && bus.op2_field[4];

    // Shifter results: immediate forms straight from the inputs, register forms from the latch.
    always_comb begin
        imm_res = imm_operand(bus.imm_flag, bus.op2_field, bus.rm_data, bus.carry_in);
        reg_res = reg_operand(rm_q, typ_q, rs_q, cin_q);
    end

    // Stage FSM: owns the output buffer and the register-shift operand latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= EMPTY;
            rm_q              <= '0;
            rs_q              <= '0;
            typ_q             <= '0;
            cin_q             <= 1'b0;
            bus.out_valid     <= 1'b0;
            bus.cond          <= '0;
            bus.operation     <= '0;
            bus.data1         <= '0;
            bus.data2         <= '0;
            bus.shifter_carry <= 1'b0;
        end else begin
            case (state)
                EMPTY, FULL: begin
                    if (accept) begin
                        // Pass-through fields are taken now; data2 follows from the latch
                        // for register forms, and out_valid stays low until it does.
                        bus.cond      <= bus.cond_in;
                        bus.operation <= bus.operation_in;
                        bus.data1     <= bus.rn_data;
                        if (reg_form) begin
                            rm_q          <= bus.rm_data;
                            rs_q          <= bus.rs_data[7:0];
                            typ_q         <= bus.op2_field[6:5];
                            cin_q         <= bus.carry_in;
                            bus.out_valid <= 1'b0;
                            state         <= SHIFT;
                        end else begin
                            bus.data2         <= imm_res[31:0];
                            bus.shifter_carry <= imm_res[32];
                            bus.out_valid     <= 1'b1;
                            state             <= FULL;
                        end
                    end else if (state == FULL && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= EMPTY;
                    end
                end
                SHIFT: begin
                    bus.data2         <= reg_res[31:0];
                    bus.shifter_carry <= reg_res[32];
                    bus.out_valid     <= 1'b1;
                    state             <= FULL;
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    state         <= EMPTY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_operand2_shifter.sv
// Bench for operand2_shifter: directed vectors plus a bit-serial reference model.
// Model predicts buffer occupancy and the result; compare runs on every falling edge.
// out_ready is driven both directed and pseudo-randomly to exercise backpressure.
module tb_operand2_shifter;
    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    operand2_shifter_if bus();

    operand2_shifter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: shift one bit at a time, tracking the last bit moved out.
    // kind 0=LSL 1=LSR 2=ASR 3=ROR
    function automatic logic [32:0] mdl_shift(input logic [31:0] x0, input int kind,
                                              input int count, input logic cin);
        logic [31:0] x;
        logic        c;
        x = x0;
        c = cin;
        for (int i = 0; i < count; i++) begin
            case (kind)
                0:       begin c = x[31]; x = x << 1; end
                1:       begin c = x[0];  x = x >> 1; end
                2:       begin c = x[0];  x = {x[31], x[31:1]}; end
                default: begin c = x[0];  x = {x[0], x[31:1]}; end
            endcase
        end
        return {c, x};
    endfunction

    function automatic logic [32:0] mdl_expect(input logic imm, input logic [11:0] f,
                                               input logic [31:0] rm, input logic [31:0] rs,
                                               input logic cin);
        int k;
        int n;
        int s;
        k = int'(f[6:5]);
        if (imm) return mdl_shift({24'd0, f[7:0]}, 3, 2 * int'(f[11:8]), cin);
        if (!f[4]) begin
            n = int'(f[11:7]);
            if (n != 0) return mdl_shift(rm, k, n, cin);
            if (k == 0) return {cin, rm};
            if (k == 3) return {rm[0], cin, rm[31:1]};
            return mdl_shift(rm, k, 32, cin);
        end
        s = int'(rs[7:0]);
        if (k == 3 && s != 0) return mdl_shift(rm, 3, (s % 32 == 0) ? 32 : s % 32, cin);
        return mdl_shift(rm, k, s, cin);
    endfunction

    // Model state: m_valid = result visible, m_pend = register shift in progress.
    logic        m_live = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_pend = 1'b0;
    logic [3:0]  m_cond = '0;
    logic [4:0]  m_op = '0;
    logic [31:0] m_d1 = '0;
    logic [31:0] m_d2 = '0;
    logic        m_c = 1'b0;
    logic        m_zero = 1'b0;

    function automatic logic m_in_ready();
        return !m_pend && (!m_valid || bus.out_ready);
    endfunction

    always @(posedge clk) begin
        logic        acc;
        logic [32:0] r;
        m_live = 1'b1;
        if (!reset) begin
            m_valid = 1'b0; m_pend = 1'b0; m_zero = 1'b1;
            m_cond = '0; m_op = '0; m_d1 = '0; m_d2 = '0; m_c = 1'b0;
        end else begin
            acc = bus.in_valid && m_in_ready();
            if (m_pend) begin
                m_pend  = 1'b0;
                m_valid = 1'b1;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
            if (acc) begin
                r = mdl_expect(bus.imm_flag, bus.op2_field, bus.rm_data, bus.rs_data,
                               bus.carry_in);
                m_d2 = r[31:0]; m_c = r[32];
                m_cond = bus.cond_in; m_op = bus.operation_in; m_d1 = bus.rn_data;
                m_zero = 1'b0;
                if (!bus.imm_flag && bus.op2_field[4]) m_pend = 1'b1;
                else m_valid = 1'b1;
            end
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready", bus.in_ready, m_in_ready());
            chk("out_valid", bus.out_valid, m_valid);
            if (m_valid || m_zero) begin
                chk("data2", bus.data2, m_d2);
                chk("shifter_carry", bus.shifter_carry, m_c);
                chk("cond", bus.cond, m_cond);
                chk("operation", bus.operation, m_op);
                chk("data1", bus.data1, m_d1);
            end
        end
    end

    task automatic set_in(input logic imm, input logic [11:0] f, input logic [31:0] rm,
                          input logic [31:0] rs, input logic cin);
        bus.cond_in      = 4'($urandom);
        bus.operation_in = 5'($urandom);
        bus.rn_data      = $urandom;
        bus.imm_flag     = imm;
        bus.op2_field    = f;
        bus.rm_data      = rm;
        bus.rs_data      = rs;
        bus.carry_in     = cin;
        bus.in_valid     = 1'b1;
    endtask

    // Offer one instruction and wait (bounded) for it to be taken; returns at accept edge + 1.
    task automatic offer(input logic imm, input logic [11:0] f, input logic [31:0] rm,
                         input logic [31:0] rs, input logic cin, input logic rnd);
        logic ok;
        ok = 1'b0;
        if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
        set_in(imm, f, rm, rs, cin);
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (!ok) bus.out_ready = 1'b1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 20 cycles required 1");
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [7:0] rs_tab [8] = '{8'd0, 8'd1, 8'd4, 8'd31, 8'd32, 8'd33, 8'd40, 8'd255};

    initial begin
        // Pin the reference model with hand-computed values.
        chk("model_rrx",   mdl_expect(1'b0, 12'h060, 32'h80000001, 0, 1'b1), 33'h1C0000000);
        chk("model_asr40", mdl_expect(1'b0, 12'h050, 32'h80000000, 40, 1'b0), 33'h1FFFFFFFF);
        chk("model_ror32", mdl_expect(1'b0, 12'h070, 32'h80000001, 32, 1'b0), 33'h180000001);
        chk("model_lsl1",  mdl_expect(1'b0, 12'h080, 32'hC0000000, 0, 1'b0), 33'h180000000);

        // Reset held with an offer present.
        reset = 1'b0;
        bus.out_ready = 1'b1;
        set_in(1'b1, 12'h4FF, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_data2", bus.data2, 32'h0);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // Immediate rotate: 0xFF ror 8.
        offer(1'b1, 12'h4FF, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rot_valid", bus.out_valid, 1'b1);
        chk("rot_data2", bus.data2, 32'hFF000000);
        chk("rot_carry", bus.shifter_carry, 1'b1);

        // Immediate zero-amount encodings.
        offer(1'b0, 12'h020, 32'h80000001, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("lsr0_data2", bus.data2, 32'h0);
        chk("lsr0_carry", bus.shifter_carry, 1'b1);
        offer(1'b0, 12'h040, 32'h80000001, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("asr0_data2", bus.data2, 32'hFFFFFFFF);
        chk("asr0_carry", bus.shifter_carry, 1'b1);
        offer(1'b0, 12'h060, 32'h80000001, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("rrx_data2", bus.data2, 32'hC0000000);
        chk("rrx_carry", bus.shifter_carry, 1'b1);

        // Register LSL with two-cycle latency.
        offer(1'b0, 12'h010, 32'h0000000F, 32'd4, 1'b1, 1'b0);
        @(negedge clk);
        chk("rs4_shift_valid", bus.out_valid, 1'b0);
        chk("rs4_shift_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("rs4_valid", bus.out_valid, 1'b1);
        chk("rs4_data2", bus.data2, 32'h000000F0);
        chk("rs4_carry", bus.shifter_carry, 1'b0);
        offer(1'b0, 12'h010, 32'h0000000F, 32'd32, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rs32_data2", bus.data2, 32'h0);
        chk("rs32_carry", bus.shifter_carry, 1'b1);
        offer(1'b0, 12'h010, 32'h0000000F, 32'd33, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("rs33_data2", bus.data2, 32'h0);
        chk("rs33_carry", bus.shifter_carry, 1'b0);

        // Backpressure hold, then same-edge swap.
        drain();
        bus.out_ready = 1'b0;
        offer(1'b1, 12'h0AB, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_data2", bus.data2, 32'h000000AB);
            chk("bp_in_ready", bus.in_ready, 1'b0);
        end
        set_in(1'b1, 12'h1FF, 32'h0, 32'h0, 1'b0);
        bus.out_ready = 1'b1;
        #1;
        chk("swap_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("swap_valid", bus.out_valid, 1'b1);
        chk("swap_data2", bus.data2, 32'hC000003F);
        chk("swap_carry", bus.shifter_carry, 1'b1);

        // Reset during the SHIFT cycle aborts the register shift.
        drain();
        set_in(1'b0, 12'h010, 32'h0000000F, 32'd4, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_valid", bus.out_valid, 1'b0);
            chk("abort_data2", bus.data2, 32'h0);
            chk("abort_in_ready", bus.in_ready, 1'b1);
        end
        offer(1'b1, 12'h4FF, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_abort_data2", bus.data2, 32'hFF000000);
        chk("post_abort_carry", bus.shifter_carry, 1'b1);

        // Mixed traffic with random out_ready; checked by the model.
        for (int i = 0; i < 40; i++) begin
            logic [11:0] f;
            f = 12'($urandom);
            if (i % 3 == 0) f[4] = 1'b1;
            offer(1'($urandom_range(0, 1)), f, $urandom, {24'($urandom), rs_tab[i % 8]},
                  1'($urandom_range(0, 1)), 1'b1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test required finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/operand2_shifter.md
# operand2_shifter

Pipelined ARM Operand2 stage sitting directly upstream of the ALU. It accepts a decoded data-processing instruction (condition, 5-bit ALU opcode, Rn/Rm/Rs values, I bit, 12-bit operand field, current C flag). It computes the ARM shifter operand and shifter carry-out, then presents data1/data2/operation/cond to the ALU from a registered one-entry output buffer with valid/ready handshake. Register-specified shifts take one extra cycle.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; clears all state when 0 at a rising edge
- in_valid  in  1  upstream offers an instruction
- in_ready  out  1  stage can accept this cycle
- cond_in  in  4  condition code, passed through
- operation_in  in  5  ALU opcode, passed through
- rn_data  in  32  first operand, passed to data1
- rm_data  in  32  value to be shifted (I=0)
- rs_data  in  32  shift-amount register; only bits [7:0] used
- imm_flag  in  1  ARM I bit
- op2_field  in  12  instruction bits [11:0]
- carry_in  in  1  current C flag
- out_valid  out  1  output buffer holds a result
- out_ready  in  1  ALU side consumes the result this cycle
- cond  out  4  to ALU cond
- operation  out  5  to ALU operation
- data1  out  32  to ALU data1 (= rn_data)
- data2  out  32  shifter operand
- shifter_carry  out  1  shifter carry-out

## Operation
- States: EMPTY, SHIFT, FULL. Reset -> EMPTY. All outputs are 0 in reset: out_valid, cond, operation, data1, data2, shifter_carry.
- in_ready = (EMPTY) or (FULL and out_ready); 0 in SHIFT.
- Accept = in_valid & in_ready. A form is register-shift when imm_flag=0 and op2_field[4]=1. All other forms are immediate.
- Immediate form accepted: the result is written to the output buffer; next state FULL.
- Register-shift form accepted: inputs are latched; next state SHIFT. SHIFT always lasts exactly one cycle, then writes the buffer and goes to FULL.
- FULL with out_ready and no accept -> EMPTY. FULL with out_ready and accept -> immediate form stays FULL with the new data, register-shift form goes to SHIFT. FULL without out_ready -> hold; outputs must remain bit-stable.
- Immediate rotate (I=1): r = 2*op2_field[11:8]; data2 = ror(op2_field[7:0], r). Carry = carry_in if r=0, else data2[31].
- Immediate shift (I=0, bit4=0): n = op2_field[11:7]; type = op2_field[6:5].
  - LSL: n=0 -> Rm, carry_in; else Rm<<n, carry Rm[32-n].
  - LSR: n=0 means 32 -> 0, carry Rm[31]; else Rm>>n, carry Rm[n-1].
  - ASR: n=0 means 32 -> 32 copies of Rm[31], carry Rm[31]; else arithmetic shift, carry Rm[n-1].
  - ROR: n=0 -> RRX {carry_in, Rm[31:1]}, carry Rm[0]; else ror by n, carry Rm[n-1].
- Register shift: s = rs_data[7:0]; if s=0 the result is Rm with carry_in for every type.
  - LSL: s<32 -> Rm<<s, carry Rm[32-s]; s=32 -> 0, carry Rm[0]; s>32 -> 0, carry 0.
  - LSR: s<32 -> Rm>>s, carry Rm[s-1]; s=32 -> 0, carry Rm[31]; s>32 -> 0, carry 0.
  - ASR: s>=32 -> sign fill, carry Rm[31].
  - ROR: s[4:0]=0 -> Rm, carry Rm[31]; else ror by s[4:0], carry Rm[s[4:0]-1].
- op2_field[7]=1 with a register shift is undefined in ARM. The stage uses op2_field[6:5] regardless; no error is raised.
- cond, operation, data1 are registered copies of the accepted inputs, aligned with data2.

## Timing
- Immediate latency is 1 cycle: accepted at edge N, out_valid=1 after edge N.
- Register-shift latency is 2 cycles: accepted at edge N, out_valid=1 after edge N+1. in_ready=0 during the SHIFT cycle.
- Throughput: 1 per cycle for back-to-back immediate forms with out_ready=1. A register shift costs one bubble.
- carry_in and rm/rs values are sampled at accept, never later.
- Reset low at any edge, including in SHIFT or FULL, aborts in-flight work. The next state is EMPTY and all outputs are 0 on the following cycle. in_valid is ignored during reset.

## Test plan
- Reset: hold reset=0 with in_valid=1 for 2 cycles -> out_valid=0, data2=0, in_ready=1 after release.
- Immediate rotate: I=1, op2=0x4FF, carry_in=0 -> data2=0xFF000000, shifter_carry=1, out_valid one cycle after accept.
- Immediate edge cases, each with Rm=0x80000001 and carry_in=1:
  - LSR #0 -> data2=0, carry=1.
  - ASR #0 -> data2=0xFFFFFFFF, carry=1.
  - ROR #0 (RRX) -> data2=0xC0000000, carry=1.
- Register shift, Rm=0x0000000F, LSL:
  - Rs=4 -> data2=0xF0, carry=0, out_valid two cycles after accept, in_ready=0 in SHIFT.
  - Rs=32 -> data2=0, carry=1.
  - Rs=33 -> data2=0, carry=0.
- Backpressure: out_ready=0 for 3 cycles while FULL -> outputs stable and in_ready=0. Then raise out_ready with a new immediate offer -> swap in the same edge, out_valid stays 1.
- Mid-op reset: accept a register shift, assert reset in the SHIFT cycle -> no output produced, state EMPTY, the next accept behaves normally.
